// File: rtl/dpsram_fifo_pkg.sv
// Shared constants and helpers for the dual-port-SRAM FIFO controller.
package dpsram_fifo_pkg;

    localparam int AW_DEF     = 5;
    localparam int DW_DEF     = 2;
    localparam int CW_DEF     = AW_DEF + 1;
    localparam int AEMPTY_DEF = 1;

    function automatic int depth_f(input int aw);
        return 32'sd1 << aw;
    endfunction

    localparam int AFULL_DEF = depth_f(AW_DEF) - 2;

endpackage

// File: rtl/dpsram.sv
// Dual-port SRAM: port A read/write, port X read (write optional); registered
// addresses with combinational read-out, so a write is visible the same cycle.
module dpsram #(
    parameter int AW = 5,
    parameter int DW = 2
) (
    input  logic          clk_i,
    input  logic          ena_i,
    input  logic [AW-1:0] adr_i,
    input  logic [DW-1:0] dat_i,
    input  logic          wre_i,
    output logic [DW-1:0] dat_o,
    input  logic [AW-1:0] xadr_i,
    input  logic [DW-1:0] xdat_i,
    input  logic          xwre_i,
    output logic [DW-1:0] xdat_o
);

    logic [DW-1:0] mem_r [2**AW];
    logic [AW-1:0] adr_r;
    logic [AW-1:0] xadr_r;

    // Array writes and address capture, both gated by the clock enable.
    always_ff @(posedge clk_i) begin
        if (ena_i) begin
            if (wre_i) begin
                mem_r[adr_i] <= dat_i;
            end
            if (xwre_i) begin
                mem_r[xadr_i] <= xdat_i;
            end
            adr_r  <= adr_i;
            xadr_r <= xadr_i;
        end
    end

    assign dat_o  = mem_r[adr_r];
    assign xdat_o = mem_r[xadr_r];

endmodule

// File: rtl/dpsram_fifo_flags.sv
// Occupancy flags decoded from the registered count, plus sticky
// overflow/underflow indicators.
module dpsram_fifo_flags
    import dpsram_fifo_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int AFULL  = depth_f(AW) - 2,
    parameter int AEMPTY = AEMPTY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ena_i,
    input  logic        flush_i,
    input  logic [AW:0] count_i,
    input  logic        push_rej_i,
    input  logic        pop_rej_i,
    output logic        full_o,
    output logic        afull_o,
    output logic        valid_o,
    output logic        aempty_o,
    output logic        ovf_o,
    output logic        udf_o
);

    localparam int          CW       = AW + 1;
    localparam logic [AW:0] DEPTH_C  = CW'(depth_f(AW));
    localparam logic [AW:0] AFULL_C  = CW'(AFULL);
    localparam logic [AW:0] AEMPTY_C = CW'(AEMPTY);

    logic ovf_r;
    logic udf_r;

    // Sticky refusal flags; only reset or flush clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (ena_i) begin
            if (flush_i) begin
                ovf_r <= 1'b0;
                udf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r | push_rej_i;
                udf_r <= udf_r | pop_rej_i;
            end
        end else begin
            ovf_r <= ovf_r;
            udf_r <= udf_r;
        end
    end

    assign full_o   = (count_i == DEPTH_C);
    assign afull_o  = (count_i >= AFULL_C);
    assign valid_o  = (count_i != {CW{1'b0}});
    assign aempty_o = (count_i <= AEMPTY_C);
    assign ovf_o    = ovf_r;
    assign udf_o    = udf_r;

endmodule

// File: rtl/dpsram_fifo.sv
// First-word-fall-through FIFO controller driving an external dual-port SRAM;
// the read port is fed the post-pop head address so dat_o is always the head.
module dpsram_fifo
    import dpsram_fifo_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int AFULL  = depth_f(AW) - 2,
    parameter int AEMPTY = AEMPTY_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] pdat_i,
    output logic          full_o,
    output logic          afull_o,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [DW-1:0] dat_o,
    output logic          aempty_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    output logic          udf_o,
    output logic          ram_ena_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_wre_o,
    output logic [AW-1:0] ram_xadr_o,
    input  logic [DW-1:0] ram_xdat_i
);

    localparam int CW = AW + 1;

    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          pop_ok_s;
    logic          push_ok_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok_s  = pop_i & valid_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);

    // Pointer and occupancy update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (ena_i) begin
            if (flush_i) begin
                wptr_r  <= {AW{1'b0}};
                rptr_r  <= {AW{1'b0}};
                count_r <= {CW{1'b0}};
            end else begin
                wptr_r  <= wptr_r + AW'(push_ok_s);
                rptr_r  <= rptr_r + AW'(pop_ok_s);
                count_r <= count_r + CW'(push_ok_s) - CW'(pop_ok_s);
            end
        end else begin
            wptr_r  <= wptr_r;
            rptr_r  <= rptr_r;
            count_r <= count_r;
        end
    end

    dpsram_fifo_flags #(
        .AW     (AW),
        .AFULL  (AFULL),
        .AEMPTY (AEMPTY)
    ) u_flags (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ena_i      (ena_i),
        .flush_i    (flush_i),
        .count_i    (count_r),
        .push_rej_i (push_i & ~push_ok_s),
        .pop_rej_i  (pop_i & ~valid_o),
        .full_o     (full_o),
        .afull_o    (afull_o),
        .valid_o    (valid_o),
        .aempty_o   (aempty_o),
        .ovf_o      (ovf_o),
        .udf_o      (udf_o)
    );

    assign count_o    = count_r;
    assign dat_o      = ram_xdat_i;
    assign ram_ena_o  = ena_i;
    assign ram_adr_o  = wptr_r;
    assign ram_dat_o  = pdat_i;
    assign ram_wre_o  = push_ok_s & ~flush_i;
    assign ram_xadr_o = rptr_r + AW'(pop_ok_s);

endmodule

// File: tb/tb_dpsram_fifo.sv
// Randomised and directed bench for dpsram_fifo against a queue-based model.
module tb_dpsram_fifo;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, ena, flush, push, pop;
    logic [DW-1:0] pdat;
    logic          full, afull, valid, aempty, ovf, udf;
    logic [DW-1:0] dat;
    logic [AW:0]   count;
    logic          ram_ena, ram_wre;
    logic [AW-1:0] ram_adr, ram_xadr;
    logic [DW-1:0] ram_dat, ram_xdat, ram_adat;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf, m_udf;
    int            m_wcnt;

    always #5 clk = ~clk;

    dpsram_fifo #(.AW(AW), .DW(DW), .AFULL(3), .AEMPTY(1)) dut (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .flush_i(flush),
        .push_i(push), .pdat_i(pdat), .full_o(full), .afull_o(afull),
        .pop_i(pop), .valid_o(valid), .dat_o(dat), .aempty_o(aempty),
        .count_o(count), .ovf_o(ovf), .udf_o(udf),
        .ram_ena_o(ram_ena), .ram_adr_o(ram_adr), .ram_dat_o(ram_dat),
        .ram_wre_o(ram_wre), .ram_xadr_o(ram_xadr), .ram_xdat_i(ram_xdat)
    );

    dpsram #(.AW(AW), .DW(DW)) u_ram (
        .clk_i(clk), .ena_i(ram_ena), .adr_i(ram_adr), .dat_i(ram_dat),
        .wre_i(ram_wre), .dat_o(ram_adat), .xadr_i(ram_xadr),
        .xdat_i(8'h00), .xwre_i(1'b0), .xdat_o(ram_xdat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational SRAM drive, advance the model, check state.
    task automatic cyc();
        logic pop_ok, push_ok;
        #1;
        pop_ok  = pop && (q.size() != 0);
        push_ok = push && ((q.size() < DEPTH) || pop_ok);
        chk("ram_ena", 32'(ram_ena), 32'(ena));
        chk("ram_dat", 32'(ram_dat), 32'(pdat));
        if (!rst) begin
            chk("ram_wre", 32'(ram_wre), 32'(push_ok && !flush));
            chk("ram_adr", 32'(ram_adr), 32'(m_wcnt % DEPTH));
        end
        @(posedge clk);
        if (rst) begin
            q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_wcnt = 0;
        end else if (ena) begin
            if (flush) begin
                q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_wcnt = 0;
            end else begin
                if (pop && !pop_ok) m_udf = 1'b1;
                if (push && !push_ok) m_ovf = 1'b1;
                if (pop_ok) void'(q.pop_front());
                if (push_ok) begin
                    q.push_back(pdat);
                    m_wcnt++;
                end
            end
        end
        #1;
        chk("count", 32'(count), q.size());
        chk("valid", 32'(valid), 32'(q.size() != 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("afull", 32'(afull), 32'(q.size() >= 3));
        chk("aempty", 32'(aempty), 32'(q.size() <= 1));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
        if (q.size() != 0) chk("dat", 32'(dat), 32'(q[0]));
    endtask

    task automatic drv(input logic r, input logic e, input logic f,
                       input logic pu, input logic [DW-1:0] d, input logic po);
        rst = r; ena = e; flush = f; push = pu; pdat = d; pop = po;
        cyc();
    endtask

    initial begin
        m_ovf = 1'b0; m_udf = 1'b0; m_wcnt = 0;
        drv(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_aempty", 32'(aempty), 32'd1);

        // Single push: latency one, head visible.
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
        chk("first_dat", 32'(dat), 32'h11);
        chk("first_cnt", 32'(count), 32'd1);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Fill, overflow attempt, then drain in order.
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
        chk("ovf_set", 32'(ovf), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain_dat", 32'(dat), 32'hA0 + i);
            drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("drain_valid", 32'(valid), 32'd0);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Push+pop while full: count holds and the new word lands behind.
        drv(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b1, 1'b0, 1'b1, 8'hB0 + 8'(i), 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        chk("full_pp_cnt", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_head", 32'(dat), 32'h77);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // count==1 with simultaneous push and pop.
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1);
        chk("pp1_dat", 32'(dat), 32'h02);
        chk("pp1_cnt", 32'(count), 32'd1);

        // Flush overrides a concurrent push.
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0);
        drv(1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0);
        chk("flush_cnt", 32'(count), 32'd0);

        // Clock enable low freezes everything.
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h21, 1'b0);
        drv(1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
        chk("hold_cnt", 32'(count), 32'd2);
        chk("hold_dat", 32'(dat), 32'h21);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drv(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom),
                1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpsram_fifo.md
Name: dpsram_fifo

Overview:
- Synchronous FIFO controller that acts as the initiator for the team's dual-port SRAM.
- Pushes write through SRAM port A (read/write port); reads use SRAM port X (read-only port).
- The SRAM registers its addresses on the clock edge and its read data follows the registered address combinationally, so this block presents the next head address every cycle. The result is a first-word-fall-through output with no extra output register.
- Sits between a streaming producer/consumer pair and one external SRAM instance.

Parameters:
- AW, 5, address width; FIFO depth = 2**AW.
- DW, 2, data width; must match the SRAM DW.
- AFULL, (2**AW)-2, almost-full threshold; afull_o=1 when count >= AFULL.
- AEMPTY, 1, almost-empty threshold; aempty_o=1 when count <= AEMPTY.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- ena_i  in  1  global clock enable; when 0, all state holds.
- flush_i  in  1  synchronous empty; SRAM contents are untouched.
- push_i  in  1  write request.
- pdat_i  in  DW  write data.
- full_o  out  1  count == 2**AW.
- afull_o  out  1  almost full.
- pop_i  in  1  consume head.
- valid_o  out  1  count != 0; dat_o holds the head.
- dat_o  out  DW  head data, passed through from ram_xdat_i.
- aempty_o  out  1  almost empty.
- count_o  out  AW+1  occupancy.
- ovf_o  out  1  sticky: push refused.
- udf_o  out  1  sticky: pop refused.
- ram_ena_o  out  1  drives SRAM ena_i; equals ena_i.
- ram_adr_o  out  AW  SRAM port A address; equals wptr.
- ram_dat_o  out  DW  SRAM port A write data; equals pdat_i.
- ram_wre_o  out  1  SRAM port A write enable; equals push_ok.
- ram_xadr_o  out  AW  SRAM port X address.
- ram_xdat_i  in  DW  SRAM port X read data.

Behaviour:
- Reset (rst_i=1 at an edge, regardless of ena_i):
  - wptr=rptr=0, count=0.
  - ovf/udf=0; valid_o=0, full_o=0, afull_o=0, aempty_o=1.
  - Reset mid-operation discards all queued words.
- pop_ok = pop_i & valid_o.
- push_ok = push_i & (!full_o | pop_ok). A push into a full FIFO is accepted when a pop is accepted in the same cycle.
- ram_xadr_o = rptr + pop_ok, combinational, with modulo 2**AW wrap.
  - The SRAM therefore registers the post-pop head address at the same edge that rptr advances.
- On an edge with ena_i=1 and !rst_i:
  - wptr += push_ok; rptr += pop_ok.
  - count += push_ok - pop_ok.
- Pointers wrap modulo 2**AW. count saturates by construction and never exceeds 2**AW or goes below 0.
- Read-during-write ordering:
  - The SRAM is write-first on the shared edge: after the edge, the array holds the new word and the registered X address selects it.
  - Empty FIFO, push at edge N: valid_o=1 and dat_o=pushed word in the cycle after edge N (latency 1).
  - count==1 with simultaneous push and pop: ram_xadr_o equals wptr, so the new word appears on dat_o the next cycle.
- Push when full with no pop: the word is dropped, ram_wre_o=0, ovf_o sets.
- pop_i when empty: ignored, udf_o sets.
- ovf_o and udf_o clear only on rst_i or flush_i.
- flush_i (ena_i=1): same effect as reset on pointers, count and flags. It has priority over a same-cycle push/pop, so no write is issued that cycle.
- ena_i=0:
  - No state changes and ram_ena_o=0.
  - Outputs hold. dat_o stays valid because the SRAM's address register also holds.
- Flags (full_o, afull_o, valid_o, aempty_o) are combinational from registered count only, never from push_i or pop_i.

Decomposition:
- Shared package holds:
  - a depth constant function (2**AW);
  - the count-width constant (AW+1);
  - default threshold constants.
- One natural sub-module, dpsram_fifo_flags:
  - takes count;
  - produces full_o, afull_o, valid_o, aempty_o;
  - holds the sticky ovf/udf registers.
- The pointer/count datapath stays in the top module. The bench instantiates the real SRAM and ties its xdat_i/xwre_i to 0.

Test Plan (AW=2, DW=8, AFULL=3, AEMPTY=1):
- Reset then push 0x11 for one cycle -> next cycle valid_o=1, dat_o=0x11, count_o=1, aempty_o=1.
- Push 0xA0,0xA1,0xA2,0xA3 back-to-back, then pop 4 -> full_o=1 after the 4th push and afull_o=1 at count 3. Pops return A0..A3 in order, then valid_o=0.
- Full FIFO, push 0x55 with no pop -> ovf_o=1, count stays 4, contents are unchanged on drain.
- Full FIFO, push 0x77 and pop in the same cycle -> count stays 4. After 3 more pops the head is 0x77 (confirms wrap and the write-first slot).
- count==1 (head 0x01), push 0x02 and pop together -> next cycle dat_o=0x02, count_o=1.
- Mid-stream checks:
  - flush_i with push_i=1 -> count 0, ram_wre_o=0 that cycle, ovf/udf cleared.
  - ena_i=0 for 3 cycles with push_i/pop_i active -> no change in count or dat_o.
